// File: rtl/esd_pkg.sv
// Shared E-STOP timing defaults and counter widths, used by the input
// conditioner and the downstream shutdown controller.
package esd_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT    = 50000;
    localparam int unsigned DISCREPANCY_CYCLES_DEFAULT = 5000000;

    localparam int unsigned DEBOUNCE_CNT_W    = 20;
    localparam int unsigned DISCREPANCY_CNT_W = 24;

    typedef logic [DEBOUNCE_CNT_W-1:0]    debounce_cnt_t;
    typedef logic [DISCREPANCY_CNT_W-1:0] discrepancy_cnt_t;

    // Raw-level reset values: E-STOP inputs assume pressed, ACK assumes released
    localparam logic ESTOP_RESET_LEVEL = 1'b0;
    localparam logic ACK_RESET_LEVEL   = 1'b1;

endpackage

// File: rtl/esd_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for one raw input.
// level_next exposes the debounced value the next edge will load.
module esd_debounce
    import esd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic level_next
);

    localparam debounce_cnt_t LIMIT = debounce_cnt_t'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    debounce_cnt_t cnt;
    debounce_cnt_t cnt_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= RESET_LEVEL;
            sync2 <= RESET_LEVEL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Accept the new level once it has differed for DEBOUNCE_CYCLES consecutive samples
    always_comb begin
        level_next = level;
        cnt_next   = '0;
        if (sync2 != level) begin
            if (cnt == LIMIT) begin
                level_next = sync2;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level <= RESET_LEVEL;
            cnt   <= '0;
        end else begin
            level <= level_next;
            cnt   <= cnt_next;
        end
    end

endmodule

// File: rtl/estop_input_conditioner.sv
// Dual-channel E-STOP and ACK input conditioning: synchronize, debounce,
// detect channel discrepancy and request a trip from the shutdown controller.
module estop_input_conditioner
    import esd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES    = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned DISCREPANCY_CYCLES = DISCREPANCY_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       estop_a_n,
    input  logic       estop_b_n,
    input  logic       ack_n,
    output logic       estop_active,
    output logic       discrepancy_fault,
    output logic       trip_req,
    output logic       ack_pulse,
    output logic [1:0] chan_state
);

    localparam discrepancy_cnt_t DISC_LIMIT = discrepancy_cnt_t'(DISCREPANCY_CYCLES);

    logic             a_level;
    logic             a_next;
    logic             b_level;
    logic             b_next;
    logic             ack_level;
    logic             ack_next;
    discrepancy_cnt_t disc_cnt;

    esd_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (ESTOP_RESET_LEVEL)
    ) u_deb_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw        (estop_a_n),
        .level      (a_level),
        .level_next (a_next)
    );

    esd_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (ESTOP_RESET_LEVEL)
    ) u_deb_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw        (estop_b_n),
        .level      (b_level),
        .level_next (b_next)
    );

    esd_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (ACK_RESET_LEVEL)
    ) u_deb_ack (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw        (ack_n),
        .level      (ack_level),
        .level_next (ack_next)
    );

    assign chan_state = {~b_level, ~a_level};
    assign trip_req   = estop_active | discrepancy_fault;

    // estop_active and ack_pulse load from the debouncers' next values so they
    // change on the same edge as chan_state; a fault set outranks an ACK clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estop_active      <= 1'b1;
            ack_pulse         <= 1'b0;
            disc_cnt          <= '0;
            discrepancy_fault <= 1'b0;
        end else begin
            estop_active <= ~a_next | ~b_next;
            ack_pulse    <= ack_level & ~ack_next;

            if (chan_state[0] != chan_state[1]) begin
                if (disc_cnt < DISC_LIMIT) begin
                    disc_cnt <= disc_cnt + 1'b1;
                end
            end else begin
                disc_cnt <= '0;
            end

            if (disc_cnt >= DISC_LIMIT) begin
                discrepancy_fault <= 1'b1;
            end else if (ack_pulse && chan_state == 2'b00) begin
                discrepancy_fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_estop_input_conditioner.sv
// Scoreboard bench for estop_input_conditioner: a history-based reference model
// predicts every cycle's outputs, a separate monitor compares them.
module tb_estop_input_conditioner;

    localparam int DEB  = 4;
    localparam int DISC = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       estop_a_n;
    logic       estop_b_n;
    logic       ack_n;
    logic       estop_active;
    logic       discrepancy_fault;
    logic       trip_req;
    logic       ack_pulse;
    logic [1:0] chan_state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0] chan;
        logic       active;
        logic       fault;
        logic       trip;
        logic       ack;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state; index 0 = A, 1 = B, 2 = ACK (raw levels)
    logic        m_s1[3];
    logic        m_s2[3];
    logic        m_db[3];
    logic [15:0] m_hist[3];
    int          m_len[3];
    int          m_run;
    logic        m_fault;
    logic        m_ack_pulse;

    estop_input_conditioner #(
        .DEBOUNCE_CYCLES    (DEB),
        .DISCREPANCY_CYCLES (DISC)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .estop_a_n         (estop_a_n),
        .estop_b_n         (estop_b_n),
        .ack_n             (ack_n),
        .estop_active      (estop_active),
        .discrepancy_fault (discrepancy_fault),
        .trip_req          (trip_req),
        .ack_pulse         (ack_pulse),
        .chan_state        (chan_state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the specified behaviour: a debounced level flips when the
    // last DEB synchronized samples all disagree with it
    task automatic modelStep(input logic r, input logic [2:0] raw);
        logic [2:0]  rl;
        logic [1:0]  pre_chan;
        logic        pre_pulse;
        logic        pre_ack_db;
        logic [15:0] mask;
        rl         = 3'b100;
        mask       = 16'((1 << DEB) - 1);
        pre_chan   = {~m_db[1], ~m_db[0]};
        pre_pulse  = m_ack_pulse;
        pre_ack_db = m_db[2];
        if (!r) begin
            for (int ch = 0; ch < 3; ch++) begin
                m_s1[ch]   = rl[ch];
                m_s2[ch]   = rl[ch];
                m_db[ch]   = rl[ch];
                m_hist[ch] = '0;
                m_len[ch]  = 0;
            end
            m_run       = 0;
            m_fault     = 1'b0;
            m_ack_pulse = 1'b0;
        end else begin
            for (int ch = 0; ch < 3; ch++) begin
                m_hist[ch] = {m_hist[ch][14:0], m_s2[ch]};
                if (m_len[ch] < DEB) m_len[ch]++;
                if (m_len[ch] >= DEB && (m_hist[ch] & mask) == (m_db[ch] ? 16'h0 : mask))
                    m_db[ch] = ~m_db[ch];
                m_s2[ch] = m_s1[ch];
                m_s1[ch] = raw[ch];
            end
            if (m_run >= DISC) m_fault = 1'b1;
            else if (pre_pulse && pre_chan == 2'b00) m_fault = 1'b0;
            m_run       = (pre_chan[0] != pre_chan[1]) ? m_run + 1 : 0;
            m_ack_pulse = pre_ack_db && !m_db[2];
        end
    endtask

    task automatic applyStimulus(input logic r, input logic a, input logic b, input logic k);
        exp_t e;
        @(negedge clk);
        rst_n     = r;
        estop_a_n = a;
        estop_b_n = b;
        ack_n     = k;
        modelStep(r, {k, b, a});
        e.chan   = {~m_db[1], ~m_db[0]};
        e.active = |e.chan;
        e.fault  = m_fault;
        e.trip   = e.active | m_fault;
        e.ack    = m_ack_pulse;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("sb_chan_state", 32'(chan_state), 32'(e.chan));
                checkOutput("sb_estop_active", 32'(estop_active), 32'(e.active));
                checkOutput("sb_fault", 32'(discrepancy_fault), 32'(e.fault));
                checkOutput("sb_trip_req", 32'(trip_req), 32'(e.trip));
                checkOutput("sb_ack_pulse", 32'(ack_pulse), 32'(e.ack));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        int pulses;
        int hold[3];
        logic [2:0] lvl;
        logic r;

        rst_n = 1'b0; estop_a_n = 1'b1; estop_b_n = 1'b1; ack_n = 1'b1;

        repeat (3) applyStimulus(0, 1, 1, 1);
        checkOutput("reset_chan_state", 32'(chan_state), 32'h3);
        checkOutput("reset_trip_req", 32'(trip_req), 32'h1);
        checkOutput("reset_fault", 32'(discrepancy_fault), 32'h0);
        checkOutput("reset_ack_pulse", 32'(ack_pulse), 32'h0);

        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1, 1, 1, 1);
            if (i == 5) checkOutput("release_trip_c5", 32'(trip_req), 32'h1);
            if (i == 6) checkOutput("release_trip_c6", 32'(trip_req), 32'h0);
        end

        repeat (3) applyStimulus(1, 0, 1, 1);
        repeat (12) applyStimulus(1, 1, 1, 1);
        checkOutput("glitch_chan_state", 32'(chan_state), 32'h0);

        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1, 0, 1, 1);
            if (i == 5) checkOutput("press_a_c5", 32'(chan_state[0]), 32'h0);
            if (i == 6) begin
                checkOutput("press_a_c6", 32'(chan_state[0]), 32'h1);
                checkOutput("press_a_trip_c6", 32'(trip_req), 32'h1);
            end
        end
        repeat (12) applyStimulus(1, 1, 1, 1);

        for (int i = 1; i <= 30; i++) begin
            applyStimulus(1, 0, 1, 1);
            if (i == 22) checkOutput("fault_c22", 32'(discrepancy_fault), 32'h0);
            if (i == 23) checkOutput("fault_c23", 32'(discrepancy_fault), 32'h1);
        end
        repeat (12) applyStimulus(1, 1, 1, 1);
        checkOutput("fault_latched_trip", 32'(trip_req), 32'h1);

        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1, 1, 1, (i < 10) ? 1'b0 : 1'b1);
            if (ack_pulse) pulses++;
        end
        checkOutput("ack_clear_pulses", 32'(pulses), 32'd1);
        checkOutput("ack_clear_fault", 32'(discrepancy_fault), 32'h0);
        checkOutput("ack_clear_trip", 32'(trip_req), 32'h0);
        repeat (8) applyStimulus(1, 1, 1, 1);

        repeat (30) applyStimulus(1, 0, 1, 1);
        repeat (12) applyStimulus(1, 1, 1, 1);
        repeat (10) applyStimulus(1, 1, 0, 1);
        repeat (10) applyStimulus(1, 1, 0, 0);
        checkOutput("ack_b_pressed_fault", 32'(discrepancy_fault), 32'h1);
        repeat (12) applyStimulus(1, 1, 1, 1);
        repeat (10) applyStimulus(1, 1, 1, 0);
        repeat (10) applyStimulus(1, 1, 1, 1);

        repeat (3) applyStimulus(1, 0, 1, 1);
        repeat (40) applyStimulus(1, 0, 0, 1);
        checkOutput("both_pressed_fault", 32'(discrepancy_fault), 32'h0);
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1, 0, 0, 0);
            if (ack_pulse) pulses++;
        end
        checkOutput("ack_hold_pulses", 32'(pulses), 32'd1);
        repeat (15) applyStimulus(1, 1, 1, 1);

        repeat (18) applyStimulus(1, 0, 1, 1);
        applyStimulus(0, 0, 1, 1);
        checkOutput("midcount_reset_chan", 32'(chan_state), 32'h3);
        checkOutput("midcount_reset_fault", 32'(discrepancy_fault), 32'h0);
        repeat (30) applyStimulus(1, 1, 1, 1);
        checkOutput("midcount_after_fault", 32'(discrepancy_fault), 32'h0);

        lvl = 3'b111;
        for (int ch = 0; ch < 3; ch++) hold[ch] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int ch = 0; ch < 3; ch++) begin
                if (hold[ch] == 0) begin
                    lvl[ch]  = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
                    hold[ch] = $urandom_range(1, 12);
                end
                hold[ch]--;
            end
            r = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            applyStimulus(r, lvl[0], lvl[1], lvl[2]);
        end

        repeat (3) @(posedge clk);
        #3;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
